// File: rtl/eth_rx_multislot_if.sv
// Bundle of the AXIS receive, host read and statistics signals of eth_rx_multislot.
// Signal names match the block's original flat port list.
interface eth_rx_multislot_if #(
   parameter int data_width_p = 64,
   parameter int eth_mtu_p    = 2048,
   parameter int stat_width_p = 16
);
   localparam int bytes_lp      = data_width_p / 8;
   localparam int addr_width_lp = $clog2(eth_mtu_p);
   localparam int size_width_lp = $clog2(eth_mtu_p + 1);

   logic [data_width_p-1:0]  rx_axis_tdata_i;
   logic [bytes_lp-1:0]      rx_axis_tkeep_i;
   logic                     rx_axis_tvalid_i;
   logic                     rx_axis_tready_o;
   logic                     rx_axis_tlast_i;
   logic                     rx_axis_tuser_i;

   logic                     packet_avail_o;
   logic [size_width_lp-1:0] packet_rsize_o;
   logic                     packet_rvalid_i;
   logic [addr_width_lp-1:0] packet_raddr_i;
   logic [data_width_p-1:0]  packet_rdata_o;
   logic                     packet_ack_i;

   logic [stat_width_p-1:0]  good_count_o;
   logic [stat_width_p-1:0]  bad_count_o;
   logic [stat_width_p-1:0]  drop_count_o;

   modport master (
      output rx_axis_tdata_i, rx_axis_tkeep_i, rx_axis_tvalid_i,
      output rx_axis_tlast_i, rx_axis_tuser_i,
      input  rx_axis_tready_o,
      input  packet_avail_o, packet_rsize_o, packet_rdata_o,
      output packet_rvalid_i, packet_raddr_i, packet_ack_i,
      input  good_count_o, bad_count_o, drop_count_o
   );

   modport slave (
      input  rx_axis_tdata_i, rx_axis_tkeep_i, rx_axis_tvalid_i,
      input  rx_axis_tlast_i, rx_axis_tuser_i,
      output rx_axis_tready_o,
      output packet_avail_o, packet_rsize_o, packet_rdata_o,
      input  packet_rvalid_i, packet_raddr_i, packet_ack_i,
      output good_count_o, bad_count_o, drop_count_o
   );
endinterface

// File: rtl/eth_rx_multislot.sv
// Multi-slot Ethernet AXIS receive buffer: good frames land in a ring of fixed slots, read in order.
// Define ETH_RX_DROP_WHEN_FULL_EN to drop frames arriving on a full ring instead of back-pressuring.
module eth_rx_multislot #(
   parameter int data_width_p = 64,
   parameter int eth_mtu_p    = 2048,
   parameter int slots_p      = 4,
   parameter int stat_width_p = 16
) (
   input  logic                clk_i,
   input  logic                reset_ni,
   eth_rx_multislot_if.slave   rx_if
);
   localparam int bytes_lp      = data_width_p / 8;
   localparam int words_lp      = eth_mtu_p / bytes_lp;
   localparam int addr_width_lp = $clog2(eth_mtu_p);
   localparam int size_width_lp = $clog2(eth_mtu_p + 1);
   localparam int offs_lp       = $clog2(bytes_lp);
   localparam int word_aw_lp    = addr_width_lp - offs_lp;
   localparam int slot_w_lp     = $clog2(slots_p);
   localparam int ptr_w_lp      = $clog2(words_lp + 1);
   localparam int fill_w_lp     = $clog2(slots_p + 1);
   localparam int mem_aw_lp     = slot_w_lp + word_aw_lp;
   localparam int mem_depth_lp  = 1 << mem_aw_lp;

   typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_DROP} state_e;

   state_e                   state_q, state_d;
   logic [slot_w_lp-1:0]     wr_slot_q, wr_slot_d;
   logic [slot_w_lp-1:0]     rd_slot_q, rd_slot_d;
   logic [fill_w_lp-1:0]     fill_q, fill_d;
   logic [ptr_w_lp-1:0]      word_ptr_q, word_ptr_d;
   logic [stat_width_p-1:0]  good_q, good_d;
   logic [stat_width_p-1:0]  bad_q, bad_d;
   logic [stat_width_p-1:0]  drop_q, drop_d;
   logic [size_width_lp-1:0] size_q [slots_p];
   logic [size_width_lp-1:0] size_d [slots_p];
   logic [data_width_p-1:0]  rdata_q, rdata_d;
   logic                     live_q, live_d;

   logic [data_width_p-1:0]  mem [mem_depth_lp];

   logic                     ring_full;
   logic                     avail;
   logic                     tready;
   logic                     beat;
   logic                     discard;
   logic                     wr_en;
   logic                     commit;
   logic                     bad_inc;
   logic                     drop_inc;
   logic                     release_slot;
   logic [size_width_lp-1:0] keep_len;
   logic [size_width_lp-1:0] frame_size;
   logic [mem_aw_lp-1:0]     wr_addr;
   logic [mem_aw_lp-1:0]     rd_addr;

   assign ring_full = (fill_q == fill_w_lp'(slots_p));
   assign avail     = (fill_q != '0);

   // tready depends only on state, fill and reset release, never on tvalid.
   always_comb begin
      tready = 1'b0;
      case (state_q)
         ST_IDLE: begin
`ifdef ETH_RX_DROP_WHEN_FULL_EN
            tready = live_q;
`else
            tready = live_q && !ring_full;
`endif
         end
         ST_FILL: tready = live_q;
         ST_DROP: tready = live_q;
         default: tready = 1'b0;
      endcase
   end

   assign beat = rx_if.rx_axis_tvalid_i && tready;

`ifdef ETH_RX_DROP_WHEN_FULL_EN
   assign discard = (state_q == ST_DROP) || ((state_q == ST_IDLE) && ring_full);
`else
   assign discard = (state_q == ST_DROP);
`endif

   always_comb begin
      keep_len = '0;
      for (int unsigned i = 0; i < bytes_lp; i++) begin
         if (rx_if.rx_axis_tkeep_i[i]) keep_len = size_width_lp'(i + 1);
      end
   end

   assign frame_size = (size_width_lp'(word_ptr_q) << offs_lp) + keep_len;

   always_comb begin
      state_d    = state_q;
      word_ptr_d = word_ptr_q;
      wr_en      = 1'b0;
      commit     = 1'b0;
      bad_inc    = 1'b0;
      drop_inc   = 1'b0;
      if (beat) begin
         if (discard) begin
            if (rx_if.rx_axis_tlast_i) begin
               drop_inc = 1'b1;
               state_d  = ST_IDLE;
            end else begin
               state_d  = ST_DROP;
            end
         end else if (rx_if.rx_axis_tlast_i) begin
            wr_en      = 1'b1;
            word_ptr_d = '0;
            state_d    = ST_IDLE;
            if (rx_if.rx_axis_tuser_i) bad_inc = 1'b1;
            else                       commit  = 1'b1;
         end else if (word_ptr_q == ptr_w_lp'(words_lp - 1)) begin
            // A non-last beat in the final word slot can only overflow the slot.
            word_ptr_d = '0;
            state_d    = ST_DROP;
         end else begin
            wr_en      = 1'b1;
            word_ptr_d = word_ptr_q + ptr_w_lp'(1);
            state_d    = ST_FILL;
         end
      end
   end

   assign release_slot = rx_if.packet_ack_i && avail;

   always_comb begin
      wr_slot_d = wr_slot_q + slot_w_lp'(commit);
      rd_slot_d = rd_slot_q + slot_w_lp'(release_slot);
      fill_d    = fill_q;
      case ({commit, release_slot})
         2'b10:   fill_d = fill_q + fill_w_lp'(1);
         2'b01:   fill_d = fill_q - fill_w_lp'(1);
         default: fill_d = fill_q;
      endcase
      size_d = size_q;
      if (commit) size_d[wr_slot_q] = frame_size;
   end

   always_comb begin
      good_d = good_q;
      bad_d  = bad_q;
      drop_d = drop_q;
      if (commit   && (good_q != '1)) good_d = good_q + stat_width_p'(1);
      if (bad_inc  && (bad_q  != '1)) bad_d  = bad_q  + stat_width_p'(1);
      if (drop_inc && (drop_q != '1)) drop_d = drop_q + stat_width_p'(1);
   end

   assign wr_addr = {wr_slot_q, word_ptr_q[word_aw_lp-1:0]};
   assign rd_addr = {rd_slot_q, rx_if.packet_raddr_i[addr_width_lp-1:offs_lp]};

   always_comb begin
      rdata_d = rdata_q;
      if (rx_if.packet_rvalid_i && avail) rdata_d = mem[rd_addr];
   end

   assign live_d = 1'b1;

   always_ff @(posedge clk_i) begin
      if (wr_en) mem[wr_addr] <= rx_if.rx_axis_tdata_i;
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q    <= ST_IDLE;
         wr_slot_q  <= '0;
         rd_slot_q  <= '0;
         fill_q     <= '0;
         word_ptr_q <= '0;
         good_q     <= '0;
         bad_q      <= '0;
         drop_q     <= '0;
         rdata_q    <= '0;
         live_q     <= 1'b0;
         for (int unsigned i = 0; i < slots_p; i++) size_q[i] <= '0;
      end else begin
         state_q    <= state_d;
         wr_slot_q  <= wr_slot_d;
         rd_slot_q  <= rd_slot_d;
         fill_q     <= fill_d;
         word_ptr_q <= word_ptr_d;
         good_q     <= good_d;
         bad_q      <= bad_d;
         drop_q     <= drop_d;
         rdata_q    <= rdata_d;
         live_q     <= live_d;
         size_q     <= size_d;
      end
   end

   generate
      if (offs_lp > 0) begin : g_raddr_low
         logic unused_raddr_low;
         assign unused_raddr_low = ^rx_if.packet_raddr_i[offs_lp-1:0];
      end
   endgenerate

   assign rx_if.rx_axis_tready_o = tready;
   assign rx_if.packet_avail_o   = avail;
   assign rx_if.packet_rsize_o   = avail ? size_q[rd_slot_q] : '0;
   assign rx_if.packet_rdata_o   = rdata_q;
   assign rx_if.good_count_o     = good_q;
   assign rx_if.bad_count_o      = bad_q;
   assign rx_if.drop_count_o     = drop_q;
endmodule

// File: tb/tb_eth_rx_multislot.sv
// Self-checking bench for eth_rx_multislot: directed and random frames against a frame-queue model.
// Expectations follow ETH_RX_DROP_WHEN_FULL_EN when it is defined.
module tb_eth_rx_multislot;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   eth_rx_multislot_if #(.data_width_p(64), .eth_mtu_p(2048), .stat_width_p(16)) bus ();
   eth_rx_multislot_if #(.data_width_p(32), .eth_mtu_p(64), .stat_width_p(2)) sbus ();

   eth_rx_multislot #(.data_width_p(64), .eth_mtu_p(2048), .slots_p(4), .stat_width_p(16))
      dut (.clk_i(clk), .reset_ni(rst_n), .rx_if(bus));

   eth_rx_multislot #(.data_width_p(32), .eth_mtu_p(64), .slots_p(2), .stat_width_p(2))
      sdut (.clk_i(clk), .reset_ni(rst_n), .rx_if(sbus));

   int n_cmp = 0;
   int n_mis = 0;
   int next_fid = 1;
   int exp_good = 0, exp_bad = 0, exp_drop = 0;
   int q_id[$];
   int q_size[$];
   logic [63:0] last_rd = '0;
   logic [31:0] salt;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] wordf(input int fid, input int w);
      logic [31:0] h;
      h = (fid * 32'h9E3779B1) ^ (w * 32'h85EBCA6B) ^ salt;
      return {h, 8'(fid), 8'hC3, 16'(w)};
   endfunction

   function automatic int cap16(input int v);
      return (v > 65535) ? 65535 : v;
   endfunction

   task automatic wait_accept(input string tag);
      int n;
      n = 0;
      @(negedge clk);
      while (bus.rx_axis_tready_o !== 1'b1 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 1000) begin
         n_cmp++;
         n_mis++;
         $error("FAIL %s: tready wait expired observed=%0d cycles expected<1000", tag, n);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic check_head(input string tag);
      chk({tag, " avail"}, 64'(bus.packet_avail_o), 64'(q_id.size() != 0));
      chk({tag, " rsize"}, 64'(bus.packet_rsize_o), (q_id.size() != 0) ? 64'(q_size[0]) : 64'd0);
      chk({tag, " good"},  64'(bus.good_count_o), 64'(cap16(exp_good)));
      chk({tag, " bad"},   64'(bus.bad_count_o),  64'(cap16(exp_bad)));
      chk({tag, " drop"},  64'(bus.drop_count_o), 64'(cap16(exp_drop)));
   endtask

   task automatic send_frame(input int nbeats, input logic [7:0] lkeep, input bit bad, input bit ack_last);
      int fid, sz, k;
      logic [7:0] v;
      bit full;
      fid = next_fid;
      next_fid++;
      k = 0;
      v = lkeep;
      while (v != 0) begin
         k++;
         v = v >> 1;
      end
      sz = (nbeats - 1) * 8 + k;
      full = (q_id.size() == 4);
      for (int b = 0; b < nbeats; b++) begin
         bus.rx_axis_tdata_i  = wordf(fid, b);
         bus.rx_axis_tkeep_i  = (b == nbeats - 1) ? lkeep : 8'($urandom);
         bus.rx_axis_tuser_i  = (b == nbeats - 1) ? bad : 1'($urandom);
         bus.rx_axis_tlast_i  = (b == nbeats - 1);
         bus.rx_axis_tvalid_i = 1'b1;
         if (ack_last && b == nbeats - 1) bus.packet_ack_i = 1'b1;
         wait_accept("beat");
      end
      bus.rx_axis_tvalid_i = 1'b0;
      bus.rx_axis_tlast_i  = 1'b0;
      bus.packet_ack_i     = 1'b0;
      if (ack_last && q_id.size() != 0) begin
         void'(q_id.pop_front());
         void'(q_size.pop_front());
      end
      if (nbeats > 256) exp_drop++;
`ifdef ETH_RX_DROP_WHEN_FULL_EN
      else if (full) exp_drop++;
`endif
      else if (bad) exp_bad++;
      else begin
         exp_good++;
         q_id.push_back(fid);
         q_size.push_back(sz);
      end
   endtask

   task automatic send_bytes(input int n, input bit bad, input bit ack_last);
      int nb, r;
      nb = (n + 7) / 8;
      r = n - (nb - 1) * 8;
      send_frame(nb, 8'hFF >> (8 - r), bad, ack_last);
   endtask

   task automatic read_head(input string tag);
      int nw;
      if (q_id.size() == 0) return;
      nw = (q_size[0] + 7) / 8;
      for (int w = 0; w < nw; w++) begin
         bus.packet_rvalid_i = 1'b1;
         bus.packet_raddr_i  = 11'(w * 8 + $urandom_range(0, 7));
         @(posedge clk);
         #1;
         last_rd = wordf(q_id[0], w);
         chk({tag, " rdata"}, bus.packet_rdata_o, last_rd);
      end
      bus.packet_rvalid_i = 1'b0;
      @(posedge clk);
      #1;
      chk({tag, " rdata hold"}, bus.packet_rdata_o, last_rd);
   endtask

   task automatic ack_head(input string tag);
      bus.packet_ack_i = 1'b1;
      @(posedge clk);
      #1;
      bus.packet_ack_i = 1'b0;
      if (q_id.size() != 0) begin
         void'(q_id.pop_front());
         void'(q_size.pop_front());
      end
      check_head(tag);
   endtask

   task automatic small_frame(input logic [31:0] d, input logic [3:0] keep, input bit user);
      int n;
      sbus.rx_axis_tdata_i  = d;
      sbus.rx_axis_tkeep_i  = keep;
      sbus.rx_axis_tuser_i  = user;
      sbus.rx_axis_tlast_i  = 1'b1;
      sbus.rx_axis_tvalid_i = 1'b1;
      n = 0;
      @(negedge clk);
      while (sbus.rx_axis_tready_o !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) begin
         n_cmp++;
         n_mis++;
         $error("FAIL small ready: wait expired observed=%0d cycles expected<100", n);
      end
      @(posedge clk);
      #1;
      sbus.rx_axis_tvalid_i = 1'b0;
   endtask

   initial begin
      salt = $urandom;
      bus.rx_axis_tdata_i = '0;  bus.rx_axis_tkeep_i = '0;  bus.rx_axis_tvalid_i = 1'b0;
      bus.rx_axis_tlast_i = 1'b0; bus.rx_axis_tuser_i = 1'b0; bus.packet_rvalid_i = 1'b0;
      bus.packet_raddr_i = '0;   bus.packet_ack_i = 1'b0;
      sbus.rx_axis_tdata_i = '0; sbus.rx_axis_tkeep_i = '0; sbus.rx_axis_tvalid_i = 1'b0;
      sbus.rx_axis_tlast_i = 1'b0; sbus.rx_axis_tuser_i = 1'b0; sbus.packet_rvalid_i = 1'b0;
      sbus.packet_raddr_i = '0;  sbus.packet_ack_i = 1'b0;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset tready", 64'(bus.rx_axis_tready_o), 64'd0);
      chk("reset rdata", bus.packet_rdata_o, 64'd0);
      check_head("reset");
      rst_n = 1'b1;
      #1;
      chk("release tready", 64'(bus.rx_axis_tready_o), 64'd0);
      @(posedge clk);
      #1;
      chk("first cycle tready", 64'(bus.rx_axis_tready_o), 64'd1);

      // 60-byte good frame
      send_bytes(60, 1'b0, 1'b0);
      check_head("f60");
      chk("f60 rsize60", 64'(bus.packet_rsize_o), 64'd60);
      read_head("f60");
      ack_head("f60 ack");

      // Bad frame then 16-byte good frame
      send_frame(3, 8'hFF, 1'b1, 1'b0);
      send_bytes(16, 1'b0, 1'b0);
      check_head("bad+16");
      read_head("bad+16");
      ack_head("bad+16 ack");

      // Oversize drop, oversize with tuser, then a full-MTU frame
      send_bytes(2056, 1'b0, 1'b0);
      check_head("oversize");
      send_bytes(2100, 1'b1, 1'b0);
      check_head("oversize bad");
      send_bytes(2048, 1'b0, 1'b0);
      check_head("mtu");
      read_head("mtu");
      ack_head("mtu ack");

      // Read and ack while empty are ignored
      bus.packet_rvalid_i = 1'b1;
      bus.packet_raddr_i  = '0;
      bus.packet_ack_i    = 1'b1;
      @(posedge clk);
      #1;
      bus.packet_rvalid_i = 1'b0;
      bus.packet_ack_i    = 1'b0;
      chk("empty read ignored", bus.packet_rdata_o, last_rd);
      check_head("empty ack ignored");

      // Fill the ring, then a fifth frame
      for (int i = 0; i < 4; i++) send_bytes(64, 1'b0, 1'b0);
      check_head("ring full");
`ifdef ETH_RX_DROP_WHEN_FULL_EN
      send_bytes(64, 1'b0, 1'b0);
      check_head("full drop");
`else
      bus.rx_axis_tdata_i  = wordf(next_fid, 0);
      bus.rx_axis_tkeep_i  = 8'hFF;
      bus.rx_axis_tlast_i  = 1'b0;
      bus.rx_axis_tvalid_i = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("full backpressure", 64'(bus.rx_axis_tready_o), 64'd0);
      end
      @(posedge clk);
      #1;
      ack_head("full ack");
      send_bytes(64, 1'b0, 1'b0);
      check_head("fifth stored");
`endif
      while (q_id.size() != 0) begin
         read_head("drain");
         ack_head("drain ack");
      end

      // Commit and ack in the same cycle with two frames held
      send_bytes($urandom_range(1, 100), 1'b0, 1'b0);
      send_bytes($urandom_range(1, 100), 1'b0, 1'b0);
      send_bytes($urandom_range(1, 100), 1'b0, 1'b1);
      check_head("commit+ack");
      chk("commit+ack depth", 64'(q_id.size()), 64'd2);
      read_head("commit+ack");
      ack_head("commit+ack a1");
      read_head("commit+ack 2");
      ack_head("commit+ack a2");
      chk("commit+ack empty", 64'(bus.packet_avail_o), 64'd0);

      // Last-beat keep patterns
      send_frame(2, 8'h00, 1'b0, 1'b0);
      check_head("keep0");
      read_head("keep0");
      ack_head("keep0 ack");
      send_frame(2, 8'b0100_0001, 1'b0, 1'b0);
      check_head("keep sparse");
      read_head("keep sparse");
      ack_head("keep sparse ack");

      // Random traffic
      for (int i = 0; i < 30; i++) begin
         int n;
         bit bad;
`ifndef ETH_RX_DROP_WHEN_FULL_EN
         if (q_id.size() == 4) begin
            read_head("rand pre");
            ack_head("rand pre ack");
         end
`endif
         n = ($urandom_range(0, 7) == 0) ? $urandom_range(2040, 2060) : $urandom_range(1, 200);
         bad = ($urandom_range(0, 3) == 0);
         send_bytes(n, bad, 1'b0);
         check_head("rand");
         if ($urandom_range(0, 1) == 1) begin
            read_head("rand");
            ack_head("rand ack");
         end
      end
      while (q_id.size() != 0) begin
         read_head("rand drain");
         ack_head("rand drain ack");
      end

      // Reset in the middle of a frame
      for (int b = 0; b < 3; b++) begin
         bus.rx_axis_tdata_i  = 64'($urandom);
         bus.rx_axis_tkeep_i  = 8'hFF;
         bus.rx_axis_tuser_i  = 1'b0;
         bus.rx_axis_tlast_i  = 1'b0;
         bus.rx_axis_tvalid_i = 1'b1;
         wait_accept("midreset beat");
      end
      bus.rx_axis_tvalid_i = 1'b0;
      #2;
      rst_n = 1'b0;
      exp_good = 0; exp_bad = 0; exp_drop = 0;
      q_id.delete();
      q_size.delete();
      #3;
      chk("midreset tready", 64'(bus.rx_axis_tready_o), 64'd0);
      check_head("midreset");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      send_bytes(24, 1'b0, 1'b0);
      check_head("after reset");
      read_head("after reset");
      ack_head("after reset ack");

      // Narrow instance: 2-bit counters saturate, 1-byte frame
      for (int i = 0; i < 5; i++) small_frame(32'($urandom), 4'hF, 1'b1);
      chk("small bad sat", 64'(sbus.bad_count_o), 64'((5 > 3) ? 3 : 5));
      chk("small no avail", 64'(sbus.packet_avail_o), 64'd0);
      small_frame(32'hDEADBE5A, 4'b0001, 1'b0);
      chk("small avail", 64'(sbus.packet_avail_o), 64'd1);
      chk("small rsize", 64'(sbus.packet_rsize_o), 64'd1);
      chk("small good", 64'(sbus.good_count_o), 64'd1);
      sbus.packet_rvalid_i = 1'b1;
      sbus.packet_raddr_i  = 6'd2;
      @(posedge clk);
      #1;
      sbus.packet_rvalid_i = 1'b0;
      chk("small rdata", 64'(sbus.packet_rdata_o), 64'h0000_0000_DEAD_BE5A);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end
endmodule
